// File: rtl/lcd_pkg.sv
// Shared LCD definitions: receiver/transmitter state encoding, default HD44780-style
// timing constants (in clock cycles) and the slow-command classifier.
package lcd_pkg;

  typedef enum logic [2:0] {
    PWR_WAIT,
    INIT1,
    INIT2,
    INIT3,
    INIT_FUNC,
    NIB_HI,
    NIB_LO
  } lcd_state_t;

  localparam int unsigned LCD_MIN_E_HIGH = 12;
  localparam int unsigned LCD_T_POWERON  = 750000;
  localparam int unsigned LCD_T_INIT1    = 205000;
  localparam int unsigned LCD_T_INIT2    = 5000;
  localparam int unsigned LCD_T_INIT3    = 2000;
  localparam int unsigned LCD_T_CMD      = 2000;
  localparam int unsigned LCD_T_CLEAR    = 82000;

  localparam int E_CNT_W = 16;

  // Clear display / return home commands need the long settling time.
  function automatic logic needs_clear_gap(input logic [7:0] value, input logic is_data);
    return !is_data && (value == 8'h01 || value == 8'h02 || value == 8'h03);
  endfunction

endpackage

// File: rtl/lcd_e_sampler.sv
// Registers the E strobe, measures its high width and latches the bus fields seen
// during the last high cycle; strobe marks the falling-edge detect cycle.
module lcd_e_sampler
  import lcd_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               e,
  input  logic               rs,
  input  logic               rw,
  input  logic [3:0]         data,
  output logic               strobe,
  output logic [E_CNT_W-1:0] high_cnt,
  output logic               cap_rs,
  output logic               cap_rw,
  output logic [3:0]         cap_data
);

  logic e_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      e_q      <= 1'b0;
      high_cnt <= '0;
      cap_rs   <= 1'b0;
      cap_rw   <= 1'b0;
      cap_data <= '0;
    end else begin
      e_q <= e;
      if (e) begin
        if (high_cnt != '1) high_cnt <= high_cnt + E_CNT_W'(1);
        cap_rs   <= rs;
        cap_rw   <= rw;
        cap_data <= data;
      end else begin
        high_cnt <= '0;
      end
    end
  end

  assign strobe = e_q & ~e;

endmodule

// File: rtl/lcd_nibble_receiver.sv
// Monitors a 4-bit HD44780 write bus: checks the init sequence and write timing,
// and reassembles nibble pairs into bytes.
module lcd_nibble_receiver
  import lcd_pkg::*;
#(
  parameter int unsigned MIN_E_HIGH = LCD_MIN_E_HIGH,
  parameter int unsigned T_POWERON  = LCD_T_POWERON,
  parameter int unsigned T_INIT1    = LCD_T_INIT1,
  parameter int unsigned T_INIT2    = LCD_T_INIT2,
  parameter int unsigned T_INIT3    = LCD_T_INIT3,
  parameter int unsigned T_CMD      = LCD_T_CMD,
  parameter int unsigned T_CLEAR    = LCD_T_CLEAR
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       iLCD_Enabled,
  input  logic       iLCD_RegisterSelect,
  input  logic       iLCD_ReadWrite,
  input  logic       iLCD_StrataFlashControl,
  input  logic [3:0] iLCD_Data,
  output logic [7:0] oByte,
  output logic       oByteValid,
  output logic       oByteIsData,
  output logic       oInitDone,
  output logic       oTimingViolation,
  output logic       oProtocolError
);

  localparam logic [E_CNT_W-1:0] MIN_E     = E_CNT_W'(MIN_E_HIGH);
  localparam logic [31:0]        GAP_PON   = 32'(T_POWERON);
  localparam logic [31:0]        GAP_INIT1 = 32'(T_INIT1);
  localparam logic [31:0]        GAP_INIT2 = 32'(T_INIT2);
  localparam logic [31:0]        GAP_INIT3 = 32'(T_INIT3);
  localparam logic [31:0]        GAP_CMD   = 32'(T_CMD);
  localparam logic [31:0]        GAP_CLEAR = 32'(T_CLEAR);

  logic               strobe, cap_rs, cap_rw;
  logic [E_CNT_W-1:0] high_cnt;
  logic [3:0]         cap_data;

  lcd_e_sampler u_sampler (
    .clk      (Clock),
    .reset    (Reset),
    .e        (iLCD_Enabled),
    .rs       (iLCD_RegisterSelect),
    .rw       (iLCD_ReadWrite),
    .data     (iLCD_Data),
    .strobe   (strobe),
    .high_cnt (high_cnt),
    .cap_rs   (cap_rs),
    .cap_rw   (cap_rw),
    .cap_data (cap_data)
  );

  lcd_state_t  state, state_n;
  logic [31:0] gap_cnt, req_gap, req_n;
  logic [3:0]  hi_nib, hi_n;
  logic        hi_rs, rs_n;
  logic [7:0]  byte_n;
  logic        data_n, valid_n, tv_n, pe_n, init_n;
  logic        edge_live, e_short, accept, ok3, ok2;

  assign edge_live = strobe & iLCD_StrataFlashControl;
  assign e_short   = high_cnt < MIN_E;
  assign accept    = edge_live & ~e_short & ~cap_rw;
  assign ok3       = (cap_data == 4'h3) && !cap_rs;
  assign ok2       = (cap_data == 4'h2) && !cap_rs;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state            <= PWR_WAIT;
      gap_cnt          <= '0;
      req_gap          <= GAP_PON;
      hi_nib           <= '0;
      hi_rs            <= 1'b0;
      oByte            <= '0;
      oByteValid       <= 1'b0;
      oByteIsData      <= 1'b0;
      oInitDone        <= 1'b0;
      oTimingViolation <= 1'b0;
      oProtocolError   <= 1'b0;
    end else begin
      state            <= state_n;
      req_gap          <= req_n;
      hi_nib           <= hi_n;
      hi_rs            <= rs_n;
      oByte            <= byte_n;
      oByteValid       <= valid_n;
      oByteIsData      <= data_n;
      oInitDone        <= init_n;
      oTimingViolation <= tv_n;
      oProtocolError   <= pe_n;
      if (accept)                gap_cnt <= '0;
      else if (gap_cnt != '1)    gap_cnt <= gap_cnt + 32'd1;
    end
  end

  // The function-set nibble (0x2) is decoded in INIT3; INIT_FUNC commits it for one cycle.
  always_comb begin
    state_n = state;
    req_n   = req_gap;
    hi_n    = hi_nib;
    rs_n    = hi_rs;
    byte_n  = oByte;
    data_n  = oByteIsData;
    valid_n = 1'b0;
    tv_n    = 1'b0;
    pe_n    = 1'b0;
    init_n  = oInitDone;

    if (edge_live && e_short) tv_n = 1'b1;
    if (edge_live && cap_rw)  pe_n = 1'b1;

    if (state == INIT_FUNC) begin
      init_n  = 1'b1;
      state_n = NIB_HI;
    end

    if (accept) begin
      if (state != NIB_LO && gap_cnt < req_gap) tv_n = 1'b1;
      case (state)
        PWR_WAIT: begin
          state_n = INIT1;
          req_n   = GAP_INIT1;
        end
        INIT1, INIT2, INIT3: begin
          if (state == INIT1 && ok3) begin
            state_n = INIT2;
            req_n   = GAP_INIT2;
          end else if (state == INIT2 && ok3) begin
            state_n = INIT3;
            req_n   = GAP_INIT3;
          end else if (state == INIT3 && ok2) begin
            state_n = INIT_FUNC;
            req_n   = GAP_CMD;
          end else begin
            pe_n    = 1'b1;
            state_n = INIT1;
            req_n   = GAP_INIT1;
          end
        end
        NIB_HI: begin
          hi_n    = cap_data;
          rs_n    = cap_rs;
          state_n = NIB_LO;
        end
        NIB_LO: begin
          byte_n  = {hi_nib, cap_data};
          data_n  = hi_rs;
          valid_n = 1'b1;
          if (cap_rs != hi_rs) pe_n = 1'b1;
          req_n   = needs_clear_gap({hi_nib, cap_data}, hi_rs) ? GAP_CLEAR : GAP_CMD;
          state_n = NIB_HI;
        end
        default: ;
      endcase
    end
  end

endmodule
